// File: rtl/banked_natural_order_reader_if.sv
// Bundle of the readout handshake, both bank read ports and the output pair stream.
// master: the reader block; slave: the banks plus the downstream consumer.
interface banked_natural_order_reader_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  start;
    logic                  busy;
    logic                  done;

    logic                  bank0_rd_en;
    logic [8:0]            bank0_rd_addr;
    logic [DATA_WIDTH-1:0] bank0_rd_data;
    logic                  bank1_rd_en;
    logic [8:0]            bank1_rd_addr;
    logic [DATA_WIDTH-1:0] bank1_rd_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [9:0]            out_index;
    logic [DATA_WIDTH-1:0] out_even;
    logic [DATA_WIDTH-1:0] out_odd;

    modport master (
        input  start,
        output busy,
        output done,
        output bank0_rd_en,
        output bank0_rd_addr,
        input  bank0_rd_data,
        output bank1_rd_en,
        output bank1_rd_addr,
        input  bank1_rd_data,
        output out_valid,
        input  out_ready,
        output out_index,
        output out_even,
        output out_odd
    );

    modport slave (
        output start,
        input  busy,
        input  done,
        input  bank0_rd_en,
        input  bank0_rd_addr,
        output bank0_rd_data,
        input  bank1_rd_en,
        input  bank1_rd_addr,
        output bank1_rd_data,
        input  out_valid,
        output out_ready,
        input  out_index,
        input  out_even,
        input  out_odd
    );
endinterface

// File: rtl/banked_natural_order_reader.sv
// Streams 1024 coefficients out of the two parity-mapped banks in natural order, one
// (even, odd) pair per transfer. Pair k lives at address k in both banks; the bank holding
// the even coefficient is selected by the XOR of the bits of k.
module banked_natural_order_reader #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input logic                           clk,
    input logic                           rst,
    banked_natural_order_reader_if.master bus
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [8:0]            k_q, k_d;

    // Read in flight: set the cycle after an issue, tagged with its pair number and parity.
    logic                  inflight_q, inflight_d;
    logic                  par_q, par_d;
    logic [8:0]            k_inf_q, k_inf_d;

    // Two-entry output FIFO.
    logic [DATA_WIDTH-1:0] fifo_even_q [2];
    logic [DATA_WIDTH-1:0] fifo_even_d [2];
    logic [DATA_WIDTH-1:0] fifo_odd_q  [2];
    logic [DATA_WIDTH-1:0] fifo_odd_d  [2];
    logic [8:0]            fifo_k_q    [2];
    logic [8:0]            fifo_k_d    [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;

    logic                  head_valid;
    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [DATA_WIDTH-1:0] lane_even;
    logic [DATA_WIDTH-1:0] lane_odd;

    // Flow control, FIFO bookkeeping and lane swap of returning bank data.
    always_comb begin
        head_valid = count_q != 2'd0;
        pop        = head_valid && bus.out_ready;
        push       = inflight_q;
        // Issue only if the pair will have a FIFO slot: count + inflight - pop < 2.
        issue      = (state_q == StRun) &&
                     (({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

        inflight_d = issue;
        par_d      = ^k_q;
        k_inf_d    = k_q;

        lane_even  = par_q ? bus.bank1_rd_data : bus.bank0_rd_data;
        lane_odd   = par_q ? bus.bank0_rd_data : bus.bank1_rd_data;

        fifo_even_d = fifo_even_q;
        fifo_odd_d  = fifo_odd_q;
        fifo_k_d    = fifo_k_q;
        if (push) begin
            fifo_even_d[wr_ptr_q] = lane_even;
            fifo_odd_d[wr_ptr_q]  = lane_odd;
            fifo_k_d[wr_ptr_q]    = k_inf_q;
        end
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
    end

    // Readout sequencing: pair counter advances on every issue and never wraps past 511.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                    k_d     = 9'd0;
                end
            end
            StRun: begin
                if (issue) begin
                    if (k_q == 9'd511) begin
                        state_d = StDrain;
                    end else begin
                        k_d = k_q + 9'd1;
                    end
                end
            end
            StDrain: begin
                // Look at the post-pop occupancy so done follows the last accept directly.
                if (!inflight_q && (count_d == 2'd0)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode; the pair outputs read zero whenever the FIFO is empty.
    always_comb begin
        bus.busy          = (state_q == StRun) || (state_q == StDrain);
        bus.done          = state_q == StDone;
        bus.bank0_rd_en   = issue;
        bus.bank1_rd_en   = issue;
        bus.bank0_rd_addr = k_q;
        bus.bank1_rd_addr = k_q;
        bus.out_valid     = head_valid;
        bus.out_index     = '0;
        bus.out_even      = '0;
        bus.out_odd       = '0;
        if (head_valid) begin
            bus.out_index = {fifo_k_q[rd_ptr_q], 1'b0};
            bus.out_even  = fifo_even_q[rd_ptr_q];
            bus.out_odd   = fifo_odd_q[rd_ptr_q];
        end
    end

    // State registers with synchronous reset flushing the pipeline and FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            k_q         <= '0;
            inflight_q  <= 1'b0;
            par_q       <= 1'b0;
            k_inf_q     <= '0;
            fifo_even_q <= '{default: '0};
            fifo_odd_q  <= '{default: '0};
            fifo_k_q    <= '{default: '0};
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            inflight_q  <= inflight_d;
            par_q       <= par_d;
            k_inf_q     <= k_inf_d;
            fifo_even_q <= fifo_even_d;
            fifo_odd_q  <= fifo_odd_d;
            fifo_k_q    <= fifo_k_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: tb/tb_banked_natural_order_reader.sv
// Bench for banked_natural_order_reader: parity-mapped bank model, expected-pair queue
// filled by the stimulus, and a negedge monitor that pops and compares on every transfer.
module tb_banked_natural_order_reader;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    banked_natural_order_reader_if #(.DATA_WIDTH(DW)) bus ();

    banked_natural_order_reader #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Bank model: registered read, data one cycle after the strobe.
    logic [DW-1:0] bank0_mem [512];
    logic [DW-1:0] bank1_mem [512];
    logic [DW-1:0] rd0_q = '0;
    logic [DW-1:0] rd1_q = '0;

    always @(posedge clk) begin
        if (bus.bank0_rd_en) rd0_q <= bank0_mem[bus.bank0_rd_addr];
        if (bus.bank1_rd_en) rd1_q <= bank1_mem[bus.bank1_rd_addr];
    end
    assign bus.bank0_rd_data = rd0_q;
    assign bus.bank1_rd_data = rd1_q;

    typedef struct packed {
        logic [9:0]    idx;
        logic [DW-1:0] ev;
        logic [DW-1:0] od;
    } pair_t;

    pair_t exp_q [$];
    int    total = 0;
    int    bad   = 0;
    int    issues = 0;
    int    pops = 0;
    int    done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic push_run();
        pair_t e;
        for (int k = 0; k < 512; k++) begin
            e.idx = 10'(2 * k);
            e.ev  = DW'(2 * k);
            e.od  = DW'(2 * k + 1);
            exp_q.push_back(e);
        end
    endtask

    // Drives start for the current cycle (c0); returns #1 into c1.
    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < limit && !seen; n++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},      32'(bus.busy),          32'd0);
        chk({tag, "_done"},      32'(bus.done),          32'd0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid),     32'd0);
        chk({tag, "_rd_en0"},    32'(bus.bank0_rd_en),   32'd0);
        chk({tag, "_rd_en1"},    32'(bus.bank1_rd_en),   32'd0);
        chk({tag, "_rd_addr0"},  32'(bus.bank0_rd_addr), 32'd0);
        chk({tag, "_rd_addr1"},  32'(bus.bank1_rd_addr), 32'd0);
        chk({tag, "_out_index"}, 32'(bus.out_index),     32'd0);
        chk({tag, "_out_even"},  32'(bus.out_even),      32'd0);
        chk({tag, "_out_odd"},   32'(bus.out_odd),       32'd0);
    endtask

    // Monitor: scoreboard pops, issue ordering/flow control, stall stability, done count.
    initial begin
        logic          busy_prev;
        logic          stall_prev;
        logic          fire;
        logic [9:0]    idx_prev;
        logic [DW-1:0] ev_prev;
        logic [DW-1:0] od_prev;
        pair_t         e;
        busy_prev  = 1'b0;
        stall_prev = 1'b0;
        idx_prev   = '0;
        ev_prev    = '0;
        od_prev    = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                issues     = 0;
                pops       = 0;
                busy_prev  = 1'b0;
                stall_prev = 1'b0;
            end else begin
                if (bus.busy && !busy_prev) begin
                    issues = 0;
                    pops   = 0;
                end
                fire = bus.out_valid && bus.out_ready;
                if (bus.bank0_rd_en || bus.bank1_rd_en) begin
                    chk("rd_en_pair", 32'({bus.bank0_rd_en, bus.bank1_rd_en}), 32'd3);
                    chk("rd_addr0", 32'(bus.bank0_rd_addr), 32'(issues));
                    chk("rd_addr1", 32'(bus.bank1_rd_addr), 32'(issues));
                    chk("no_issue_past_511", 32'(issues < 512), 32'd1);
                    chk("flow_ctrl", 32'((issues - pops - int'(fire)) < 2), 32'd1);
                    issues++;
                end
                if (stall_prev) begin
                    chk("stall_valid", 32'(bus.out_valid), 32'd1);
                    chk("stall_index", 32'(bus.out_index), 32'(idx_prev));
                    chk("stall_even",  32'(bus.out_even),  32'(ev_prev));
                    chk("stall_odd",   32'(bus.out_odd),   32'(od_prev));
                end
                if (fire) begin
                    if (exp_q.size() == 0) begin
                        chk("pop_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_index", 32'(bus.out_index), 32'(e.idx));
                        chk("out_even",  32'(bus.out_even),  32'(e.ev));
                        chk("out_odd",   32'(bus.out_odd),   32'(e.od));
                    end
                    pops++;
                end
                if (bus.done) done_cnt++;
                stall_prev = bus.out_valid && !bus.out_ready;
                idx_prev   = bus.out_index;
                ev_prev    = bus.out_even;
                od_prev    = bus.out_odd;
                busy_prev  = bus.busy;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int dc0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            logic [9:0] iv;
            iv = 10'(i);
            if (^iv) bank1_mem[iv[9:1]] = DW'(i);
            else     bank0_mem[iv[9:1]] = DW'(i);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("reset");

        // Full readout, consumer always ready, cycle-accurate timing.
        bus.out_ready = 1'b1;
        push_run();
        pulse_start();
        for (int n = 1; n <= 520; n++) begin
            @(negedge clk);
            chk("t1_busy", 32'(bus.busy), 32'(n <= 514));
            chk("t1_done", 32'(bus.done), 32'(n == 515));
            if (n == 1) chk("t1_c1_rd_en", 32'(bus.bank0_rd_en), 32'd1);
            if (n == 2) chk("t1_c2_valid", 32'(bus.out_valid), 32'd0);
            if (n == 3) begin
                chk("t1_c3_valid", 32'(bus.out_valid), 32'd1);
                chk("t1_c3_index", 32'(bus.out_index), 32'd0);
            end
            if (n == 4) begin
                chk("t1_k1_even", 32'(bus.out_even), 32'd2);
                chk("t1_k1_odd",  32'(bus.out_odd),  32'd3);
            end
            if (n == 6) begin
                chk("t1_k3_even", 32'(bus.out_even), 32'd6);
                chk("t1_k3_odd",  32'(bus.out_odd),  32'd7);
            end
            if (n == 514) begin
                chk("t1_k511_index", 32'(bus.out_index), 32'd1022);
                chk("t1_k511_even",  32'(bus.out_even),  32'd1022);
                chk("t1_k511_odd",   32'(bus.out_odd),   32'd1023);
            end
            if (n >= 513) chk("t1_rd_en_after_last", 32'(bus.bank0_rd_en | bus.bank1_rd_en), 32'd0);
        end
        chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure: 1,0,1,0 then a 20-cycle stall, then ready.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        push_run();
        pulse_start();
        for (int n = 0; n < 10 && !bus.out_valid; n++) @(negedge clk);
        chk("t2_first_valid", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1;
            bus.out_ready = (i < 4) ? ~i[0] : 1'b0;
        end
        @(negedge clk);
        chk("t2_stall_no_rd_en", 32'(bus.bank0_rd_en | bus.bank1_rd_en), 32'd0);
        chk("t2_stall_valid", 32'(bus.out_valid), 32'd1);
        chk("t2_stall_held", 32'(issues - pops), 32'd2);
        chk("t2_stall_index", 32'(bus.out_index), 32'd4);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_done(1200);
        chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // Stray start pulses at c5 and c200, start during done ignored, restart after done.
        @(posedge clk);
        #1;
        dc0 = done_cnt;
        push_run();
        pulse_start();
        repeat (4) @(posedge clk);
        #1;
        pulse_start();
        repeat (194) @(posedge clk);
        #1;
        pulse_start();
        wait_done(700);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("t3_start_in_done_ignored", 32'(bus.busy), 32'd0);
        chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);
        push_run();
        pulse_start();
        chk("t3_restart_busy", 32'(bus.busy), 32'd1);
        wait_done(700);
        repeat (5) @(posedge clk);
        #1;
        chk("t3_done_count", 32'(done_cnt - dc0), 32'd2);
        chk("t3_restart_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-run after pair 100 is accepted, then a clean full readout.
        push_run();
        pulse_start();
        for (int n = 0; n < 400 && pops < 101; n++) @(posedge clk);
        chk("t4_reached_pair_100", 32'(pops >= 101), 32'd1);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        check_zero("t4_after_rst");
        push_run();
        pulse_start();
        wait_done(700);
        chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("t4_idle_busy", 32'(bus.busy), 32'd0);
        chk("t4_idle_rd_en", 32'(bus.bank0_rd_en | bus.bank1_rd_en), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/banked_natural_order_reader.md
# banked_natural_order_reader

Streams a 1024-coefficient polynomial out of the two 512-entry conflict-free banks in natural order, two coefficients per transfer (indices 2k, 2k+1). It is the read-side counterpart of the parity-bank address map. The write map puts coefficient i at bank = XOR of all bits of i and address = i>>1. This block applies the inverse mapping and swaps the bank data back into even/odd lanes. It sits between the NTT core's banks and the output/transfer interface and runs after the core reports completion.

## Interface
- DATA_WIDTH, 16, coefficient width per bank word
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a readout; ignored unless idle
- busy  out  1  high while a readout is in progress
- done  out  1  one-cycle pulse after the last pair is accepted
- bank0_rd_en  out  1  read strobe, bank 0
- bank0_rd_addr  out  9  read address, bank 0
- bank0_rd_data  in  DATA_WIDTH  bank 0 data, valid 1 cycle after bank0_rd_en
- bank1_rd_en  out  1  read strobe, bank 1
- bank1_rd_addr  out  9  read address, bank 1
- bank1_rd_data  in  DATA_WIDTH  bank 1 data, valid 1 cycle after bank1_rd_en
- out_valid  out  1  output pair available
- out_ready  in  1  consumer accepts pair when out_valid & out_ready
- out_index  out  10  natural index of even coefficient (always even)
- out_even  out  DATA_WIDTH  coefficient at out_index
- out_odd  out  DATA_WIDTH  coefficient at out_index+1

## Operation
- Pair counter k (9 bit), 0..511. Coefficients 2k and 2k+1 both sit at bank address k, in opposite banks, so every pair read is conflict-free.
- Parity p = XOR of k[8:0]. If p=0, bank0 holds even and bank1 holds odd. If p=1, they are swapped.
- Issue: bank0_rd_en = bank1_rd_en = 1, both addresses = k, same cycle. p and k are pipelined alongside the 1-cycle read latency.
- Returned data is swapped per the delayed p and written with index {k,1'b0} into a 2-entry output FIFO.
- Flow control: issue only when count + inflight − pop < 2. Here pop = out_valid & out_ready, and inflight ∈ {0,1}.
- The FIFO never overflows. Data never drops or duplicates. While out_valid & !out_ready, the out_* outputs hold stable.
- FSM states:
  - IDLE: start → RUN, k=0.
  - RUN: issues under flow control. After issuing k=511 → DRAIN. k does not wrap and address 0 is never reissued.
  - DRAIN: inflight=0 & FIFO empty → DONE.
  - DONE: done=1 for 1 cycle → IDLE.
- busy=1 in RUN and DRAIN only. start is ignored outside IDLE, including in the DONE cycle.
- rst (any state) next cycle: IDLE, k=0, FIFO and inflight flushed. busy, done, out_valid, both rd_en, both rd_addr, out_index, out_even and out_odd are all 0.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from out_ready to out_valid or out_*. out_ready may affect rd_en in the same cycle through the pop term.
- Start sampled at c0:
  - c1: RUN, rd_en=1, addr=0.
  - c2: bank data returns.
  - c3: out_valid=1, out_index=0.
- With out_ready held high, one pair is transferred per cycle. Index 1022 appears at c514. done pulses at c515, with busy=0 from c515.
- Read-to-output latency is 2 cycles when the FIFO is empty.
- Stall: out_ready low holds at most 2 pairs (count=2 or count+inflight=2). Issue resumes in the same cycle as the first pop.

## Test plan
- Preload each bank[XOR(i)][i>>1] = i for i=0..1023, start, out_ready=1. Expect 512 pairs with out_index=2k, out_even=2k, out_odd=2k+1, first at c3, done single pulse at c515, busy high c1..c514.
- Spot checks (same preload):
  - k=1 (p=1): bank1[1]=2, bank0[1]=3 → out_even=2, out_odd=3.
  - k=3 (p=0): bank0[3]=6, bank1[3]=7 → out_even=6, out_odd=7.
  - k=511 (p=1): out_even=1022, out_odd=1023.
- Backpressure: out_ready pattern 1,0,1,0 then low for 20 cycles then high. Expect an in-order, gap-free sequence, at most 2 pairs buffered, out_* stable while stalled, and no rd_en during full-FIFO stall.
- Pulse start at c5 and c200 mid-run. Expect no effect on the sequence and a single done. A start one cycle after done gives a fresh full readout from index 0.
- Assert rst during RUN after pair 100 is accepted. Next cycle all outputs are 0. start afterward restarts at out_index=0 with full 512 pairs.
- After the k=511 issue, expect no further rd_en assertions through DRAIN/DONE/IDLE, and bank addresses never wrap to 0.
